// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file command driver.
// Contents: command opcodes, driver FSM states, default data/index widths.
package regfile_pkg;

  localparam int unsigned REGFILE_DATA_WIDTH  = 16;
  localparam int unsigned REGFILE_INDEX_WIDTH = 2;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_COPY  = 2'd2,
    OP_ADDI  = 2'd3
  } regfile_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } driver_state_t;

endpackage

// File: rtl/regfile_driver.sv
// regfile_driver: command-driven initiator for register_file.
// Takes one command at a time (valid/ready), sequences the register file's
// read port A and write port, and returns one response (valid/ready).
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_op/dst/src/imm   command fields (READ, WRITE, COPY, ADDI)
//   rsp_valid/rsp_ready  response handshake
//   rsp_data             read value or value written
//   rf_read_index_a      to register_file read_index_a
//   rf_read_data_a       from register_file read_data_a (combinational)
//   rf_write_index/data/enable  to register_file write port
//   rsp_zero, rsp_carry  only when REGFILE_DRIVER_FLAGS_EN is defined
//
// Build option: `define REGFILE_DRIVER_FLAGS_EN adds rsp_zero / rsp_carry.
module regfile_driver
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = REGFILE_DATA_WIDTH,
  parameter int unsigned INDEX_WIDTH = REGFILE_INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [INDEX_WIDTH-1:0] cmd_dst,
  input  logic [INDEX_WIDTH-1:0] cmd_src,
  input  logic [DATA_WIDTH-1:0]  cmd_imm,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_data,
  output logic [INDEX_WIDTH-1:0] rf_read_index_a,
  input  logic [DATA_WIDTH-1:0]  rf_read_data_a,
  output logic [INDEX_WIDTH-1:0] rf_write_index,
  output logic [DATA_WIDTH-1:0]  rf_write_data,
  output logic                   rf_write_enable
`ifdef REGFILE_DRIVER_FLAGS_EN
  ,
  output logic                   rsp_zero,
  output logic                   rsp_carry
`endif
);

  localparam int unsigned SUM_W = DATA_WIDTH + 1;

  driver_state_t          state_q, state_d;
  regfile_op_t            op_q, op_d;
  logic [INDEX_WIDTH-1:0] dst_q, dst_d;
  logic [INDEX_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic [INDEX_WIDTH-1:0] wr_idx_q, wr_idx_d;
  logic [DATA_WIDTH-1:0]  imm_q, imm_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic                   cmd_ready_q, rsp_valid_q, wr_en_q;
  logic [DATA_WIDTH-1:0]  alu_sum_c;

  // ALU for ADDI: wrapping add of read data and latched immediate
`ifdef REGFILE_DRIVER_FLAGS_EN
  logic alu_carry_c;
  logic carry_q, carry_d;
  logic rsp_zero_q, rsp_zero_d;
  logic rsp_carry_q, rsp_carry_d;
  assign {alu_carry_c, alu_sum_c} = SUM_W'(rf_read_data_a) + SUM_W'(imm_q);
`else
  assign alu_sum_c = rf_read_data_a + imm_q;
`endif

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dst_d      = dst_q;
    imm_d      = imm_q;
    rd_idx_d   = rd_idx_q;
    wr_idx_d   = wr_idx_q;
    wr_data_d  = wr_data_q;
    rsp_data_d = rsp_data_q;
`ifdef REGFILE_DRIVER_FLAGS_EN
    carry_d     = carry_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_carry_d = rsp_carry_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d  = regfile_op_t'(cmd_op);
          dst_d = cmd_dst;
          imm_d = cmd_imm;
`ifdef REGFILE_DRIVER_FLAGS_EN
          carry_d = 1'b0;
`endif
          if (regfile_op_t'(cmd_op) == OP_WRITE) begin
            state_d   = WR;
            wr_idx_d  = cmd_dst;
            wr_data_d = cmd_imm;
          end else begin
            state_d  = RD;
            rd_idx_d = cmd_src;
          end
        end
      end
      RD: begin
        // Read data is captured here, so src==dst sees the pre-write value
        if (op_q == OP_READ) begin
          state_d    = RESP;
          rsp_data_d = rf_read_data_a;
`ifdef REGFILE_DRIVER_FLAGS_EN
          rsp_zero_d  = (rf_read_data_a == '0);
          rsp_carry_d = 1'b0;
`endif
        end else begin
          state_d   = WR;
          wr_idx_d  = dst_q;
          wr_data_d = (op_q == OP_ADDI) ? alu_sum_c : rf_read_data_a;
`ifdef REGFILE_DRIVER_FLAGS_EN
          carry_d = (op_q == OP_ADDI) ? alu_carry_c : 1'b0;
`endif
        end
      end
      WR: begin
        state_d    = RESP;
        rsp_data_d = wr_data_q;
`ifdef REGFILE_DRIVER_FLAGS_EN
        rsp_zero_d  = (wr_data_q == '0);
        rsp_carry_d = carry_q;
`endif
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; handshake/enable outputs follow the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_READ;
      dst_q       <= '0;
      imm_q       <= '0;
      rd_idx_q    <= '0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
      rsp_data_q  <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      wr_en_q     <= 1'b0;
`ifdef REGFILE_DRIVER_FLAGS_EN
      carry_q     <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_carry_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      imm_q       <= imm_d;
      rd_idx_q    <= rd_idx_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
      rsp_data_q  <= rsp_data_d;
      cmd_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == RESP);
      wr_en_q     <= (state_d == WR);
`ifdef REGFILE_DRIVER_FLAGS_EN
      carry_q     <= carry_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_carry_q <= rsp_carry_d;
`endif
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rf_read_index_a = rd_idx_q;
  assign rf_write_index  = wr_idx_q;
  assign rf_write_data   = wr_data_q;
  assign rf_write_enable = wr_en_q;
`ifdef REGFILE_DRIVER_FLAGS_EN
  assign rsp_zero  = rsp_zero_q;
  assign rsp_carry = rsp_carry_q;
`endif

endmodule

// File: tb/tb_regfile_driver.sv
// Testbench for regfile_driver with a behavioural register file responder.
module tb_regfile_driver;
  import regfile_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [IW-1:0] cmd_dst, cmd_src;
  logic [DW-1:0] cmd_imm;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [IW-1:0] rf_read_index_a, rf_write_index;
  logic [DW-1:0] rf_read_data_a, rf_write_data;
  logic          rf_write_enable;
`ifdef REGFILE_DRIVER_FLAGS_EN
  logic          rsp_zero, rsp_carry;
`endif

  always #5 clk = ~clk;

  regfile_driver #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_dst         (cmd_dst),
    .cmd_src         (cmd_src),
    .cmd_imm         (cmd_imm),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rf_read_index_a (rf_read_index_a),
    .rf_read_data_a  (rf_read_data_a),
    .rf_write_index  (rf_write_index),
    .rf_write_data   (rf_write_data),
    .rf_write_enable (rf_write_enable)
`ifdef REGFILE_DRIVER_FLAGS_EN
    ,
    .rsp_zero        (rsp_zero),
    .rsp_carry       (rsp_carry)
`endif
  );

  // Register file responder: combinational read, write on rising edge
  logic [DW-1:0] rf_mem [4];
  logic          rf_clr;
  assign rf_read_data_a = rf_mem[rf_read_index_a];
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 4; i++) rf_mem[i] <= '0;
    end else if (rf_write_enable) begin
      rf_mem[rf_write_index] <= rf_write_data;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } wr_t;

  logic [DW-1:0] rsp_q [$];
  wr_t           wr_q [$];

  // Write-port monitor: each enable cycle must match the next expected write
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    wr_t w;
    if (rf_write_enable) begin
      check("we_one_cycle", 32'(prev_we), 32'd0);
      if (wr_q.size() == 0) begin
        check("unexpected_write_idx", 32'(rf_write_index), 32'hFFFF_FFFF);
      end else begin
        w = wr_q.pop_front();
        check("write_index", 32'(rf_write_index), 32'(w.idx));
        check("write_data", 32'(rf_write_data), 32'(w.data));
      end
    end
    prev_we = rf_write_enable;
  end

  typedef struct {
    logic [1:0]    op;
    logic [IW-1:0] dst;
    logic [IW-1:0] src;
    logic [DW-1:0] imm;
    logic [DW-1:0] exp_data;
    int            exp_lat;
    logic          exp_carry;
  } vec_t;

  vec_t vecs [13];

  // Issue one command with rsp_ready high; called and returns on a negedge
  task automatic run_vec(input vec_t v);
    int  lat;
    wr_t w;
    logic [DW-1:0] e;
    lat = 0;
    while (!cmd_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_dst   = v.dst;
    cmd_src   = v.src;
    cmd_imm   = v.imm;
    rsp_q.push_back(v.exp_data);
    if (v.op != 2'(OP_READ)) begin
      w.idx  = v.dst;
      w.data = v.exp_data;
      wr_q.push_back(w);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(v.exp_lat));
    if (rsp_valid && rsp_q.size() > 0) begin
      e = rsp_q.pop_front();
      check("rsp_data", 32'(rsp_data), 32'(e));
`ifdef REGFILE_DRIVER_FLAGS_EN
      check("rsp_carry", 32'(rsp_carry), 32'(v.exp_carry));
      check("rsp_zero", 32'(rsp_zero), 32'(v.exp_data == '0));
`endif
    end
    @(negedge clk);
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    wr_t           w;
    logic [DW-1:0] e;
    int            lat;

    //          op        dst src imm       exp       lat carry
    vecs[0]  = '{2'd1, 2'd1, 2'd0, 16'h0007, 16'h0007, 2, 1'b0}; // WRITE r1=7
    vecs[1]  = '{2'd0, 2'd0, 2'd1, 16'h0000, 16'h0007, 2, 1'b0}; // READ r1
    vecs[2]  = '{2'd1, 2'd0, 2'd0, 16'hFFFF, 16'hFFFF, 2, 1'b0}; // WRITE r0=FFFF
    vecs[3]  = '{2'd3, 2'd2, 2'd0, 16'h0003, 16'h0002, 3, 1'b1}; // ADDI wraps
    vecs[4]  = '{2'd0, 2'd0, 2'd2, 16'h0000, 16'h0002, 2, 1'b0}; // READ r2
    vecs[5]  = '{2'd1, 2'd3, 2'd0, 16'h000A, 16'h000A, 2, 1'b0}; // WRITE r3=10
    vecs[6]  = '{2'd2, 2'd3, 2'd3, 16'h1234, 16'h000A, 3, 1'b0}; // COPY r3->r3
    vecs[7]  = '{2'd0, 2'd0, 2'd3, 16'h0000, 16'h000A, 2, 1'b0}; // READ r3
    vecs[8]  = '{2'd2, 2'd0, 2'd1, 16'h0000, 16'h0007, 3, 1'b0}; // COPY r1->r0
    vecs[9]  = '{2'd0, 2'd0, 2'd0, 16'h0000, 16'h0007, 2, 1'b0}; // READ r0
    vecs[10] = '{2'd3, 2'd1, 2'd1, 16'h0005, 16'h000C, 3, 1'b0}; // ADDI r1+5
    vecs[11] = '{2'd3, 2'd2, 2'd2, 16'hFFFE, 16'h0000, 3, 1'b1}; // ADDI to zero
    vecs[12] = '{2'd0, 2'd0, 2'd2, 16'h0000, 16'h0000, 2, 1'b0}; // READ r2

    reset     = 1'b1;
    rf_clr    = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_dst   = '0;
    cmd_src   = '0;
    cmd_imm   = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_write_enable", 32'(rf_write_enable), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    check("reset_read_index", 32'(rf_read_index_a), 32'd0);
`ifdef REGFILE_DRIVER_FLAGS_EN
    check("reset_rsp_zero", 32'(rsp_zero), 32'd0);
    check("reset_rsp_carry", 32'(rsp_carry), 32'd0);
`endif
    reset  = 1'b0;
    rf_clr = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Backpressure: WRITE r1=0x55 held 4 cycles while a READ waits
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'(OP_WRITE);
    cmd_dst   = 2'd1;
    cmd_imm   = 16'h0055;
    rsp_q.push_back(16'h0055);
    w.idx = 2'd1; w.data = 16'h0055;
    wr_q.push_back(w);
    @(negedge clk);
    cmd_op  = 2'(OP_READ);
    cmd_src = 2'd1;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", 32'(lat), 32'd2);
    e = rsp_q.pop_front();
    check("bp_rsp_data", 32'(rsp_data), 32'(e));
    for (int i = 0; i < 4; i++) begin
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_data", 32'(rsp_data), 32'h0055);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_ready", 32'(cmd_ready), 32'd1);
    rsp_q.push_back(16'h0055);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp_second_accepted", 32'(cmd_ready), 32'd0);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_second_latency", 32'(lat), 32'd2);
    e = rsp_q.pop_front();
    check("bp_second_data", 32'(rsp_data), 32'(e));
    @(negedge clk);

    // Reset while in WR: no further write, back to IDLE, no response
    cmd_valid = 1'b1;
    cmd_op    = 2'(OP_WRITE);
    cmd_dst   = 2'd2;
    cmd_imm   = 16'hBEEF;
    w.idx = 2'd2; w.data = 16'hBEEF;
    wr_q.push_back(w);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("wr_state_enable", 32'(rf_write_enable), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_wr_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_wr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_wr_enable", 32'(rf_write_enable), 32'd0);
    check("rst_wr_rsp_data", 32'(rsp_data), 32'd0);
`ifdef REGFILE_DRIVER_FLAGS_EN
    check("rst_wr_rsp_carry", 32'(rsp_carry), 32'd0);
`endif
    repeat (3) begin
      @(negedge clk);
      check("rst_wr_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_vec('{2'd0, 2'd0, 2'd1, 16'h0000, 16'h0055, 2, 1'b0});
    run_vec('{2'd0, 2'd0, 2'd3, 16'h0000, 16'h000A, 2, 1'b0});
    run_vec('{2'd0, 2'd0, 2'd0, 16'h0000, 16'h0007, 2, 1'b0});

    repeat (2) @(negedge clk);
    check("writes_outstanding", 32'(wr_q.size()), 32'd0);
    check("responses_outstanding", 32'(rsp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
